// File: rtl/l1_mem_arbiter_if.sv
// Bus bundle between the L1 caches, the arbiter and physical memory.
// The arbiter uses the slave modport; the surrounding environment uses master.
interface l1_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned SEL_W  = 16
);
  logic [1:0]          req_cyc;
  logic [1:0]          req_stb;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_adr;
  logic [2*SEL_W-1:0]  req_sel;
  logic [2*DATA_W-1:0] req_dat_m;
  logic [DATA_W-1:0]   req_dat_s;
  logic [1:0]          req_ack;
  logic [1:0]          req_rty;
  logic                mem_cyc;
  logic                mem_stb;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_adr;
  logic [SEL_W-1:0]    mem_sel;
  logic [DATA_W-1:0]   mem_dat_m;
  logic [DATA_W-1:0]   mem_dat_s;
  logic                mem_ack;
  logic                mem_rty;
  logic [1:0]          owner;
  logic                timeout_pulse;

  modport slave (
    input  req_cyc, req_stb, req_we, req_adr, req_sel, req_dat_m,
    input  mem_dat_s, mem_ack, mem_rty,
    output req_dat_s, req_ack, req_rty,
    output mem_cyc, mem_stb, mem_we, mem_adr, mem_sel, mem_dat_m,
    output owner, timeout_pulse
  );

  modport master (
    output req_cyc, req_stb, req_we, req_adr, req_sel, req_dat_m,
    output mem_dat_s, mem_ack, mem_rty,
    input  req_dat_s, req_ack, req_rty,
    input  mem_cyc, mem_stb, mem_we, mem_adr, mem_sel, mem_dat_m,
    input  owner, timeout_pulse
  );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one memory wishbone port between icache and dcache,
// with a watchdog that turns a stalled memory access into a retry.
module l1_mem_arbiter #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned SEL_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  l1_mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RELEASE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_owner;
  logic [1:0]       w_owner_nxt;
  logic [1:0]       r_last_owner;
  logic [1:0]       w_last_nxt;
  logic [CNT_W-1:0] r_wdog;
  logic [CNT_W-1:0] w_wdog_nxt;
  logic [1:0]       w_valid;
  logic             w_own;
  logic             w_expire;

  assign w_valid       = bus.req_cyc & bus.req_stb;
  assign w_own         = r_owner[1];
  assign bus.req_dat_s = bus.mem_dat_s;

  // last_owner resets to dcache so the icache wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= 2'b00;
      r_last_owner <= 2'b10;
      r_wdog       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_wdog       <= w_wdog_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_owner_nxt       = r_owner;
    w_last_nxt        = r_last_owner;
    w_wdog_nxt        = r_wdog;
    w_expire          = 1'b0;
    bus.mem_cyc       = 1'b0;
    bus.mem_stb       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_adr       = '0;
    bus.mem_sel       = '0;
    bus.mem_dat_m     = '0;
    bus.req_ack       = 2'b00;
    bus.req_rty       = 2'b00;
    bus.owner         = 2'b00;
    bus.timeout_pulse = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|w_valid) begin
          // last_owner is one-hot, so its inverse is the other requester
          w_owner_nxt = (&w_valid) ? ~r_last_owner : w_valid;
          w_last_nxt  = w_owner_nxt;
          w_wdog_nxt  = '0;
          w_state_nxt = ST_BUSY;
        end
      end

      ST_BUSY: begin
        bus.owner     = r_owner;
        bus.mem_cyc   = bus.req_cyc[w_own];
        bus.mem_stb   = bus.req_stb[w_own];
        bus.mem_we    = bus.req_we[w_own];
        bus.mem_adr   = w_own ? bus.req_adr[ADDR_W +: ADDR_W] : bus.req_adr[0 +: ADDR_W];
        bus.mem_sel   = w_own ? bus.req_sel[SEL_W +: SEL_W]   : bus.req_sel[0 +: SEL_W];
        bus.mem_dat_m = w_own ? bus.req_dat_m[DATA_W +: DATA_W] : bus.req_dat_m[0 +: DATA_W];

        // a real ack or rty always beats watchdog expiry
        w_expire = !bus.mem_ack && !bus.mem_rty && (r_wdog == CNT_W'(TIMEOUT - 1));

        bus.req_ack       = bus.mem_ack ? r_owner : 2'b00;
        bus.req_rty       = (bus.mem_rty || w_expire) ? r_owner : 2'b00;
        bus.timeout_pulse = w_expire;

        if (bus.mem_ack || bus.mem_rty || w_expire || !bus.req_cyc[w_own]) begin
          w_state_nxt = ST_RELEASE;
        end else if (r_wdog != CNT_W'(TIMEOUT)) begin
          w_wdog_nxt = r_wdog + CNT_W'(1);
        end
      end

      ST_RELEASE: w_state_nxt = ST_IDLE;

      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
